instr_register_fifo: RTL

// - Parametrised next-generation instruction register: stores {opcode, operand_a, operand_b}
//   and a pre-computed result per entry; sits between the stimulus/test program and checkers.
// - Two addressing modes: explicit (write_pointer/read_pointer, as before) and auto/FIFO
//   (internal wrap-around pointers, occupancy count, full/empty).
// - Registered read with valid strobe; errors flagged instead of silently dropped.

---
 rtl/instr_register_pkg.sv | 31 +++
 rtl/instr_alu.sv | 44 ++++
 rtl/instr_register_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register FIFO: opcodes, operand/result widths, stored entry.
package instr_register_pkg;

  localparam int unsigned DEPTH_DEF     = 32;
  localparam int unsigned OPERAND_W_DEF = 32;
  localparam int unsigned RESULT_W_DEF  = 64;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OPERAND_W_DEF-1:0] operand_t;
  typedef logic signed [RESULT_W_DEF-1:0]  result_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0]    address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
    logic     div_zero;
  } instr_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational result generator used on the write path; all arithmetic is signed at RESULT_W.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int unsigned OPERAND_W = 32,
  parameter int unsigned RESULT_W  = 64
) (
  input  opcode_t                     opcode,
  input  logic signed [OPERAND_W-1:0] a,
  input  logic signed [OPERAND_W-1:0] b,
  output logic signed [RESULT_W-1:0]  result,
  output logic                        div_zero
);

  logic signed [RESULT_W-1:0] a_ext;
  logic signed [RESULT_W-1:0] b_ext;

  // Widening first keeps the full product and avoids MIN/-1 quotient overflow.
  assign a_ext = {{(RESULT_W-OPERAND_W){a[OPERAND_W-1]}}, a};
  assign b_ext = {{(RESULT_W-OPERAND_W){b[OPERAND_W-1]}}, b};

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (b == '0) div_zero = 1'b1;
        else         result   = a_ext / b_ext;
      end
      MOD: begin
        if (b == '0) div_zero = 1'b1;
        else         result   = a_ext % b_ext;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_fifo.sv
// Instruction register with explicit or auto/FIFO addressing, registered read and error pulses.
module instr_register_fifo
  import instr_register_pkg::*;
#(
  parameter  int unsigned DEPTH     = 32,
  parameter  int unsigned OPERAND_W = 32,
  parameter  int unsigned RESULT_W  = 64,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic                        ptr_mode,
  input  opcode_t                     opcode,
  input  logic signed [OPERAND_W-1:0] operand_a,
  input  logic signed [OPERAND_W-1:0] operand_b,
  input  logic [ADDR_W-1:0]           write_pointer,
  input  logic [ADDR_W-1:0]           read_pointer,
  input  logic                        rd_req,
  output logic                        rd_valid,
  output instr_t                      instruction_word,
  output logic [ADDR_W:0]             count,
  output logic                        full,
  output logic                        empty,
  output logic                        wr_err,
  output logic                        rd_err
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  instr_t                     mem [DEPTH];
  instr_t                     entry;
  logic [ADDR_W-1:0]          wr_ptr;
  logic [ADDR_W-1:0]          rd_ptr;
  logic [ADDR_W-1:0]          waddr;
  logic [ADDR_W-1:0]          raddr;
  logic                       wr_ok;
  logic                       rd_ok;
  logic signed [RESULT_W-1:0] alu_result;
  logic                       alu_div_zero;

  instr_alu #(
    .OPERAND_W(OPERAND_W),
    .RESULT_W (RESULT_W)
  ) u_alu (
    .opcode  (opcode),
    .a       (operand_a),
    .b       (operand_b),
    .result  (alu_result),
    .div_zero(alu_div_zero)
  );

  always_comb begin
    entry          = '0;
    entry.opc      = opcode;
    entry.op_a     = operand_a;
    entry.op_b     = operand_b;
    entry.result   = alu_result;
    entry.div_zero = alu_div_zero;
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Occupancy limits only gate requests in auto mode; explicit accesses always proceed.
  assign wr_ok = load_en && !(ptr_mode && full);
  assign rd_ok = rd_req  && !(ptr_mode && empty);
  assign waddr = ptr_mode ? wr_ptr : write_pointer;
  assign raddr = ptr_mode ? rd_ptr : read_pointer;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      rd_valid         <= 1'b0;
      instruction_word <= '0;
      wr_err           <= 1'b0;
      rd_err           <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      wr_err   <= load_en && ptr_mode && full;
      rd_err   <= rd_req  && ptr_mode && empty;
      // Nonblocking read of mem gives read-before-write on a same-address collision.
      if (rd_ok) instruction_word <= mem[raddr];
      if (wr_ok) mem[waddr] <= entry;
      if (ptr_mode) begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
